// File: rtl/senha_coletor_if.sv
`default_nettype none
// ============================================================================
//  Module      : senha_coletor_if
//  Description : Keypad-event / password-packet bundle between the keypad
//                scanner, the password collector and the lock controller.
//                  key_code      [3:0]  key code qualified by key_valid
//                  key_valid            one-cycle key strobe
//                  digitos_value [79:0] password packet, nibble 0 = newest
//                  digitos_valid        one-cycle packet strobe
//                  n_digitos     [4:0]  digits currently buffered
//                  erro                 one-cycle rejected-confirm strobe
//                master : producer of key events, consumer of packets
//                slave  : the collector itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface senha_coletor_if;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic [4:0]  n_digitos;
    logic        erro;

    modport master (
        output key_code,
        output key_valid,
        input  digitos_value,
        input  digitos_valid,
        input  n_digitos,
        input  erro
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output digitos_value,
        output digitos_valid,
        output n_digitos,
        output erro
    );
endinterface
`default_nettype wire

// File: rtl/senha_coletor.sv
`default_nettype none
// ============================================================================
//  Module      : senha_coletor
//  Description : Password collector. Shifts typed digits into a 20-nibble
//                packet, delivers it on '#' (one-cycle digitos_valid pulse),
//                clears on '*', on inactivity timeout and when disabled,
//                and flags too-short entries with a one-cycle erro pulse.
//  Ports       : clk         clock
//                rst         asynchronous active-high reset
//                teclado_en  keypad enable; low clears the entry and packet
//                kbd         senha_coletor_if.slave (key in, packet out)
//  Revision    : 1.0 - initial release
// ============================================================================
module senha_coletor #(
    parameter int MAX_DIGITS     = 20,    // packet capacity in nibbles
    parameter int MIN_DIGITS     = 4,     // shortest accepted password
    parameter int TIMEOUT_CYCLES = 5000,  // idle cycles before discard
    parameter int TMR_W          = 16     // 2**TMR_W > TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           teclado_en,
    senha_coletor_if.slave kbd
);

    // The interface carries a fixed 80-bit packet, so MAX_DIGITS stays 20.
    localparam int PKT_W = 4 * MAX_DIGITS;
    localparam int CNT_W = 5;

    localparam logic [PKT_W-1:0] c_ALL_F    = '1;
    localparam logic [CNT_W-1:0] c_MAX_CNT  = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] c_MIN_CNT  = CNT_W'(MIN_DIGITS);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);

    localparam logic [3:0] c_KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] c_KEY_CLEAR     = 4'hA;
    localparam logic [3:0] c_KEY_CONFIRM   = 4'hB;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,   // nothing buffered, timer stopped
        S_COLLECT = 1'b1    // at least one digit buffered
    } state_t;

    state_t           state_q;
    logic [PKT_W-1:0] buf_q;
    logic [PKT_W-1:0] value_q;
    logic [CNT_W-1:0] count_q;
    logic [TMR_W-1:0] timer_q;
    logic             valid_q;
    logic             erro_q;

    // ------------------------------------------------------------------
    // Key decode. Codes 0xC-0xF decode to nothing, so in COLLECT they
    // look exactly like an idle cycle and keep the timeout running.
    // ------------------------------------------------------------------
    logic             w_is_digit;
    logic             w_is_clear;
    logic             w_is_confirm;
    logic [PKT_W-1:0] w_buf_shift;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_is_digit   = kbd.key_valid && (kbd.key_code <= c_KEY_MAX_DIGIT);
    assign w_is_clear   = kbd.key_valid && (kbd.key_code == c_KEY_CLEAR);
    assign w_is_confirm = kbd.key_valid && (kbd.key_code == c_KEY_CONFIRM);

    // Newest digit enters at nibble 0; once full, nibble 19 falls off the top.
    // Below capacity only 4'hF padding is shifted out.
    assign w_buf_shift = {buf_q[PKT_W-5:0], kbd.key_code};
    assign w_cnt_inc   = (count_q == c_MAX_CNT) ? count_q : (count_q + c_CNT_ONE);

    // ------------------------------------------------------------------
    // Collector FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= c_ALL_F;
            count_q <= '0;
            timer_q <= '0;
            value_q <= c_ALL_F;
            valid_q <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            // Both strobes are single-cycle by construction.
            valid_q <= 1'b0;
            erro_q  <= 1'b0;

            if (!teclado_en) begin
                // Disable wins over any key in the same cycle, even '#'.
                state_q <= S_IDLE;
                buf_q   <= c_ALL_F;
                count_q <= '0;
                timer_q <= '0;
                value_q <= c_ALL_F;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // '*' and '#' with an empty buffer are dropped silently.
                        if (w_is_digit) begin
                            buf_q   <= w_buf_shift;
                            count_q <= w_cnt_inc;
                            timer_q <= '0;
                            state_q <= S_COLLECT;
                        end
                    end

                    S_COLLECT: begin
                        if (w_is_digit) begin
                            buf_q   <= w_buf_shift;
                            count_q <= w_cnt_inc;
                            timer_q <= '0;
                        end else if (w_is_clear) begin
                            state_q <= S_IDLE;
                            buf_q   <= c_ALL_F;
                            count_q <= '0;
                            timer_q <= '0;
                        end else if (w_is_confirm) begin
                            // count is never 0 here, so a short entry is
                            // always a genuine rejection.
                            if (count_q >= c_MIN_CNT) begin
                                value_q <= buf_q;
                                valid_q <= 1'b1;
                            end else begin
                                erro_q  <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            buf_q   <= c_ALL_F;
                            count_q <= '0;
                            timer_q <= '0;
                        end else if (timer_q == c_TMR_LAST) begin
                            // Silent discard: value_q keeps the last packet.
                            state_q <= S_IDLE;
                            buf_q   <= c_ALL_F;
                            count_q <= '0;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + c_TMR_ONE;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        buf_q   <= c_ALL_F;
                        count_q <= '0;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign kbd.digitos_value = value_q;
    assign kbd.digitos_valid = valid_q;
    assign kbd.n_digitos     = count_q;
    assign kbd.erro          = erro_q;

endmodule
`default_nettype wire
